// File: rtl/pipeline_if_ifid_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package pipeline_if_ifid_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_FETCH = 2'd1,
      IF_HOLD  = 2'd2,
      IF_DRAIN = 2'd3
   } if_state_e;

endpackage

// File: rtl/pipeline_if_ifid_if_id_reg.sv
// IF/ID pipeline register: load wins over bubble, otherwise hold.
module if_id_reg #(
   parameter logic [31:0] NOP_INST = pipeline_if_ifid_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] pc_in,
   input  logic [31:0] inst_in,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out,
   output logic        valid_out
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;

   always_comb begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
      if (load) begin
         pc_d    = pc_in;
         inst_d  = inst_in;
         valid_d = 1'b1;
      end else if (bubble) begin
         pc_d    = 32'd0;
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= 32'd0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
      end
   end

   assign pc_out    = pc_q;
   assign inst_out  = inst_q;
   assign valid_out = valid_q;

endmodule

// File: rtl/pipeline_if_ifid.sv
// Fetch stage: PC, fetch FSM, stall buffer and redirect target feeding IF/ID.
module pipeline_if_ifid #(
   parameter logic [31:0] RESET_PC = pipeline_if_ifid_pkg::RESET_PC,
   parameter logic [31:0] NOP_INST = pipeline_if_ifid_pkg::NOP_INST
) (
   input  logic        clk_IF,
   input  logic        rst_IF,
   input  logic        stall_IF,
   input  logic        flush_IF,
   input  logic [31:0] PC_target_IF,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] PC_out_IFID,
   output logic [31:0] Inst_out_IFID,
   output logic        Valid_IFID
);

   import pipeline_if_ifid_pkg::*;

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        req_q, req_d;

   logic        ld, bub;
   logic [31:0] ld_pc, ld_inst;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      buf_d    = buf_q;
      buf_pc_d = buf_pc_q;
      tgt_d    = tgt_q;
      ld       = 1'b0;
      bub      = 1'b0;
      ld_pc    = buf_pc_q;
      ld_inst  = buf_q;
      unique case (state_q)
         IF_IDLE: state_d = IF_FETCH;
         IF_FETCH: begin
            if (flush_IF) begin
               bub = 1'b1;
               if (imem_ready) begin
                  pc_d = PC_target_IF;
               end else begin
                  tgt_d   = PC_target_IF;
                  state_d = IF_DRAIN;
               end
            end else if (stall_IF) begin
               if (imem_ready) begin
                  buf_d    = imem_rdata;
                  buf_pc_d = pc_q;
                  pc_d     = pc_q + 32'd4;
                  state_d  = IF_HOLD;
               end
            end else if (imem_ready) begin
               ld      = 1'b1;
               ld_pc   = pc_q;
               ld_inst = imem_rdata;
               pc_d    = pc_q + 32'd4;
            end else begin
               bub = 1'b1;
            end
         end
         IF_HOLD: begin
            if (flush_IF) begin
               pc_d    = PC_target_IF;
               bub     = 1'b1;
               state_d = IF_FETCH;
            end else if (!stall_IF) begin
               ld      = 1'b1;
               state_d = IF_FETCH;
            end
         end
         IF_DRAIN: begin
            // Old address stays on the bus until memory answers
            bub = 1'b1;
            if (flush_IF) tgt_d = PC_target_IF;
            if (imem_ready) begin
               pc_d    = flush_IF ? PC_target_IF : tgt_q;
               state_d = IF_FETCH;
            end
         end
         default: state_d = IF_IDLE;
      endcase
      req_d = (state_d == IF_FETCH) || (state_d == IF_DRAIN);
   end

   always_ff @(posedge clk_IF or negedge rst_IF) begin
      if (!rst_IF) begin
         state_q  <= IF_IDLE;
         pc_q     <= RESET_PC;
         buf_q    <= 32'd0;
         buf_pc_q <= 32'd0;
         tgt_q    <= 32'd0;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         buf_q    <= buf_d;
         buf_pc_q <= buf_pc_d;
         tgt_q    <= tgt_d;
         req_q    <= req_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk       (clk_IF),
      .rst_n     (rst_IF),
      .load      (ld),
      .bubble    (bub),
      .pc_in     (ld_pc),
      .inst_in   (ld_inst),
      .pc_out    (PC_out_IFID),
      .inst_out  (Inst_out_IFID),
      .valid_out (Valid_IFID)
   );

endmodule

// File: doc/pipeline_if_ifid.md
Name: pipeline_if_ifid

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns the PC and issues requests to the instruction memory over a req/ready handshake.
- Buffers a response that arrives during a stall.
- Delivers {PC, instruction, valid} to decode.
- Bubbles are inserted on memory wait states and on flushes. A flush is a branch/jump redirect from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven to decode when not valid.

Ports:
clk_IF  in  1  stage clock, rising edge.
rst_IF  in  1  asynchronous, active-low reset.
stall_IF  in  1  hazard-unit stall; hold the IF/ID register contents.
flush_IF  in  1  redirect request from EX; kill the fetched/in-flight instruction.
PC_target_IF  in  32  redirect target, sampled when flush_IF=1.
imem_rdata  in  32  instruction data, valid when imem_ready=1.
imem_ready  in  1  memory has completed the current request this cycle.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address (= PC register).
PC_out_IFID  out  32  PC of the instruction held in IF/ID.
Inst_out_IFID  out  32  instruction to decode; NOP_INST when the valid bit is 0.
Valid_IFID  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_IF=0, asynchronous):
  - PC=RESET_PC; state=IDLE; imem_req=0.
  - PC_out_IFID=0, Inst_out_IFID=NOP_INST, Valid_IFID=0.
  - buffer and target registers cleared.
  - Reset mid-request abandons the request; the memory must tolerate req dropping.
- Memory protocol:
  - While imem_req=1 and no imem_ready has been seen, imem_addr must stay constant.
  - imem_ready is legal in the same cycle as req (0-wait) or any later cycle.
- States (2-bit encoding): IDLE, FETCH, HOLD, DRAIN.
- IDLE: req=0. Next state is FETCH unconditionally. This is the first cycle after reset release.
- FETCH: req=1, addr=PC. Priority is flush > stall > normal.
  - flush & ready: PC<=PC_target_IF; IF/ID<=bubble; stay FETCH. The returned data is discarded.
  - flush & !ready: tgt<=PC_target_IF; IF/ID<=bubble; go to DRAIN. PC is held so the address stays stable.
  - stall & ready: buf<=imem_rdata; bufPC<=PC; PC<=PC+4; IF/ID held; go to HOLD.
  - stall & !ready: IF/ID held; PC held.
  - ready (no stall, no flush): IF/ID<={PC, imem_rdata, valid=1}; PC<=PC+4.
  - !ready (no stall, no flush): IF/ID<=bubble (valid=0, NOP_INST); PC held.
- HOLD: req=0.
  - flush: PC<=PC_target_IF; buffer dropped; IF/ID<=bubble; go to FETCH.
  - stall: hold everything.
  - else: IF/ID<={bufPC, buf, 1}; go to FETCH.
- DRAIN: req=1, addr=PC (the old, still-outstanding address).
  - IF/ID<=bubble every cycle, regardless of stall.
  - A new flush_IF overwrites tgt (the latest redirect wins).
  - On ready: data discarded; PC<=tgt (or PC_target_IF if flush is also asserted that cycle); go to FETCH.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No alignment checking; PC_target_IF[1:0] is passed through unchanged.
- Bubble definition: Valid_IFID=0, Inst_out_IFID=NOP_INST, PC_out_IFID=0.
- Decode latency: an instruction accepted on edge N is visible at the IF/ID outputs after edge N. There is no combinational path from imem_rdata to the outputs.
- Simultaneous flush and stall: flush wins in every state.

Decomposition:
- Shared defines file: NOP_INST, RESET_PC, and the IF state encodings (IF_IDLE, IF_FETCH, IF_HOLD, IF_DRAIN).
- One natural sub-module, if_id_reg: the {PC, Inst, Valid} register with load/hold/bubble controls and asynchronous active-low reset.
- The FSM, PC register and buffer stay in the top level.

Test Plan:
- Reset release, imem_ready tied 1, rdata=0xAABBCC00+addr:
  - First cycle after release: req=0 (IDLE).
  - Then PC_out/Inst sequence 0/0xAABBCC00, 4/0xAABBCC04, 8/... with Valid=1 every cycle.
- imem_ready low for 2 cycles at PC=8:
  - Two bubbles (Valid=0, Inst=0x13).
  - imem_addr stays at 8 throughout.
  - Then PC_out=8 is delivered.
- stall_IF=1 for 3 cycles while ready=1 at PC=0x10:
  - IF/ID frozen.
  - req drops after the capture.
  - On release, 0x10 is delivered once, then fetch resumes at 0x14. No duplicate or lost instruction.
- flush_IF with PC_target_IF=0x100 while a fetch of 0x20 is waiting (ready low 3 cycles):
  - addr stays 0x20 until ready.
  - 0x20 is never delivered.
  - Next request is addr 0x100; IF/ID shows bubbles meanwhile.
- flush_IF and stall_IF asserted together in HOLD:
  - Buffer discarded; bubble output.
  - Next fetch is at the target.
- PC=0xFFFFFFFC fetched (ready=1) -> next imem_addr=0x00000000; rst_IF asserted mid-DRAIN -> all outputs return to reset values immediately.
